// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch unit.
// Issues sequential word-aligned fetch requests over a valid/ready channel,
// buffers in-order responses in a small FIFO and presents them with their PC.
// A redirect flushes the FIFO, reloads both PCs and drops in-flight responses.
module unidade_busca #(
    parameter int          PROFUNDIDADE_FILA = 4,
    parameter int          MAX_PENDENTES     = 2,
    parameter logic [31:0] PC_INICIAL        = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        req_valido,
    input  logic        req_pronto,
    output logic [31:0] req_endereco,
    input  logic        resp_valido,
    input  logic [31:0] resp_dado,
    input  logic        desvio,
    input  logic [31:0] desvio_pc,
    output logic        instr_valido,
    input  logic        instr_pronto,
    output logic [31:0] instr_dado,
    output logic [31:0] instr_pc
);

    // Pointer width and counter width (counters must reach PROFUNDIDADE_FILA).
    localparam int PW = (PROFUNDIDADE_FILA > 1) ? $clog2(PROFUNDIDADE_FILA) : 1;
    localparam int CW = PW + 1;

    localparam logic [CW:0]   PROF_L = (CW+1)'(PROFUNDIDADE_FILA);
    localparam logic [CW-1:0] MAXP_L = CW'(MAX_PENDENTES);

    logic [31:0]   pc_busca_reg;
    logic [31:0]   pc_saida_reg;
    logic [PW-1:0] cabeca_reg;
    logic [PW-1:0] cauda_reg;
    logic [CW-1:0] contagem_reg;
    logic [CW-1:0] pendentes_reg;
    logic [CW-1:0] descartar_reg;
    logic [31:0]   fila_mem [PROFUNDIDADE_FILA];

    logic [CW:0]   ocupacao_total;
    logic          aceita;
    logic          resp_ok;
    logic          grava;
    logic          retira;
    logic [31:0]   alvo;

    // Redirect target with the byte-offset bits forced to zero.
    assign alvo = desvio_pc & 32'hFFFF_FFFC;

    // Entries already buffered plus those still in flight; reserving space for
    // every outstanding request means a response can never overflow the FIFO.
    assign ocupacao_total = {1'b0, contagem_reg} + {1'b0, pendentes_reg};

    // Request is held off during reset and in the redirect cycle, so no
    // stale-path address is ever accepted.
    assign req_valido   = !reset && !desvio
                          && (ocupacao_total < PROF_L)
                          && (pendentes_reg < MAXP_L);
    assign req_endereco = pc_busca_reg;
    assign aceita       = req_valido && req_pronto;

    // A response with nothing outstanding is spurious and is ignored.
    assign resp_ok = resp_valido && (pendentes_reg != '0);
    assign grava   = resp_ok && !desvio && (descartar_reg == '0);

    assign instr_valido = (contagem_reg != '0);
    assign instr_dado   = instr_valido ? fila_mem[cabeca_reg] : 32'h0;
    assign instr_pc     = pc_saida_reg;

    // A pop during a redirect is meaningless: the FIFO is flushed anyway.
    assign retira = instr_valido && instr_pronto && !desvio;

    // Control state: PCs, FIFO pointers and the three counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_busca_reg  <= PC_INICIAL;
            pc_saida_reg  <= PC_INICIAL;
            cabeca_reg    <= '0;
            cauda_reg     <= '0;
            contagem_reg  <= '0;
            pendentes_reg <= '0;
            descartar_reg <= '0;
        end else begin
            pendentes_reg <= pendentes_reg + CW'(aceita) - CW'(resp_ok);
            if (desvio) begin
                pc_busca_reg  <= alvo;
                pc_saida_reg  <= alvo;
                cabeca_reg    <= '0;
                cauda_reg     <= '0;
                contagem_reg  <= '0;
                // Everything still outstanding belongs to the old path; the
                // response arriving right now is dropped here directly.
                descartar_reg <= pendentes_reg - CW'(resp_ok);
            end else begin
                if (aceita) begin
                    pc_busca_reg <= pc_busca_reg + 32'd4;
                end
                if (resp_ok && (descartar_reg != '0)) begin
                    descartar_reg <= descartar_reg - 1'b1;
                end
                if (grava) begin
                    cauda_reg <= cauda_reg + 1'b1;
                end
                if (retira) begin
                    cabeca_reg   <= cabeca_reg + 1'b1;
                    pc_saida_reg <= pc_saida_reg + 32'd4;
                end
                contagem_reg <= contagem_reg + CW'(grava) - CW'(retira);
            end
        end
    end

    // FIFO storage; contents need no reset because contagem gates visibility.
    always_ff @(posedge clock) begin
        if (grava) begin
            fila_mem[cauda_reg] <= resp_dado;
        end
    end

endmodule

// File: tb/tb_unidade_busca.sv
// Testbench for unidade_busca: behavioural memory with programmable latency,
// scoreboard queue of expected PCs consumed by an independent monitor.
module tb_unidade_busca;

    localparam logic [31:0] MAGIC = 32'h5A5A_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valido;
    logic        req_pronto = 1'b1;
    logic [31:0] req_endereco;
    logic        resp_valido = 1'b0;
    logic [31:0] resp_dado = 32'h0;
    logic        desvio = 1'b0;
    logic [31:0] desvio_pc = 32'h0;
    logic        instr_valido;
    logic        instr_pronto = 1'b1;
    logic [31:0] instr_dado;
    logic [31:0] instr_pc;

    unidade_busca #(
        .PROFUNDIDADE_FILA(4),
        .MAX_PENDENTES(2),
        .PC_INICIAL(32'h0000_0000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valido(req_valido),
        .req_pronto(req_pronto),
        .req_endereco(req_endereco),
        .resp_valido(resp_valido),
        .resp_dado(resp_dado),
        .desvio(desvio),
        .desvio_pc(desvio_pc),
        .instr_valido(instr_valido),
        .instr_pronto(instr_pronto),
        .instr_dado(instr_dado),
        .instr_pc(instr_pc)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int mon_count = 0;
    logic [31:0] exp_pc_q[$];

    // Memory model state
    int          lat = 1;
    int          edge_n = 0;
    logic [31:0] mem_q[$];
    int          due_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Memory: samples accepts on the clock edge, answers in order after lat cycles.
    always begin
        @(posedge clock);
        edge_n++;
        if (reset) begin
            mem_q.delete();
            due_q.delete();
            #1;
            resp_valido = 1'b0;
            resp_dado   = 32'h0;
        end else begin
            if (req_valido && req_pronto) begin
                mem_q.push_back(req_endereco);
                due_q.push_back(edge_n + lat - 1);
            end
            #1;
            if (due_q.size() > 0 && due_q[0] <= edge_n) begin
                resp_valido = 1'b1;
                resp_dado   = mem_q.pop_front() ^ MAGIC;
                void'(due_q.pop_front());
            end else begin
                resp_valido = 1'b0;
                resp_dado   = 32'h0;
            end
        end
    end

    // Monitor: every consumed instruction must match the scoreboard head.
    always @(negedge clock) begin
        logic [31:0] e;
        if (!reset && !desvio && instr_valido && instr_pronto) begin
            if (exp_pc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got pc %h, required none", instr_pc);
            end else begin
                e = exp_pc_q.pop_front();
                check("instr_pc", instr_pc, e);
                check("instr_dado", instr_dado, e ^ MAGIC);
                mon_count++;
            end
        end
    end

    task automatic load_expected(input logic [31:0] base, input int n);
        exp_pc_q.delete();
        for (int i = 0; i < n; i++) exp_pc_q.push_back(base + 32'(4 * i));
    endtask

    task automatic redirect_now(input logic [31:0] target, input logic [31:0] exp_base);
        desvio    = 1'b1;
        desvio_pc = target;
        load_expected(exp_base, 40);
        @(posedge clock);
        #1;
        desvio = 1'b0;
    endtask

    initial begin
        int vcnt;
        int mc0;
        int exp_desc;
        logic found;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_req_valido", 32'(req_valido), 32'd0);
        check("rst_instr_valido", 32'(instr_valido), 32'd0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_instr_dado", instr_dado, 32'h0);

        // Stream with 1-cycle memory
        load_expected(32'h0, 64);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("first_req_valido", 32'(req_valido), 32'd1);
        check("first_req_endereco", req_endereco, 32'h0);
        check("cycle0_instr_valido", 32'(instr_valido), 32'd0);
        @(negedge clock);
        check("cycle1_instr_valido", 32'(instr_valido), 32'd0);
        @(negedge clock);
        check("cycle2_instr_valido", 32'(instr_valido), 32'd1);
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (instr_valido) vcnt++;
        end
        check("throughput_8_cycles", 32'(vcnt), 32'd8);

        // Backpressure: FIFO fills to 4, requests stop
        @(posedge clock);
        #1;
        instr_pronto = 1'b0;
        repeat (6) @(negedge clock);
        check("bp_contagem", 32'(dut.contagem_reg), 32'd4);
        check("bp_pendentes", 32'(dut.pendentes_reg), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_req_valido", 32'(req_valido), 32'd0);
        end
        @(posedge clock);
        #1;
        instr_pronto = 1'b1;
        repeat (10) @(negedge clock);

        // Redirect with two requests in flight, 3-cycle memory
        lat = 3;
        repeat (6) @(negedge clock);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clock);
            if (mem_q.size() == 2 && !resp_valido) found = 1'b1;
        end
        check("wait_two_in_flight", 32'(found), 32'd1);
        #1;
        mc0 = mon_count;
        redirect_now(32'h0000_0103, 32'h0000_0100);
        @(negedge clock);
        check("redir_fifo_empty", 32'(instr_valido), 32'd0);
        check("redir_descartar", 32'(dut.descartar_reg), 32'd2);
        check("redir_req_endereco", req_endereco, 32'h0000_0100);
        repeat (25) @(negedge clock);
        check("redir_consumed_ge3", 32'(mon_count - mc0 >= 3), 32'd1);

        // Redirect coinciding with a response and a pop
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clock);
            if (resp_valido && instr_valido && instr_pronto) found = 1'b1;
        end
        check("wait_resp_and_pop", 32'(found), 32'd1);
        exp_desc = mem_q.size();
        #1;
        mc0 = mon_count;
        redirect_now(32'h0000_0200, 32'h0000_0200);
        @(negedge clock);
        check("simul_fifo_empty", 32'(instr_valido), 32'd0);
        check("simul_descartar", 32'(dut.descartar_reg), 32'(exp_desc));
        repeat (25) @(negedge clock);
        check("simul_consumed_ge3", 32'(mon_count - mc0 >= 3), 32'd1);

        // Wrap-around of the PC
        lat = 1;
        #1;
        mc0 = mon_count;
        redirect_now(32'hFFFF_FFF8, 32'hFFFF_FFF8);
        repeat (12) @(negedge clock);
        check("wrap_consumed_ge4", 32'(mon_count - mc0 >= 4), 32'd1);

        // Reset mid-operation with entries buffered and requests in flight
        @(posedge clock);
        #1;
        instr_pronto = 1'b0;
        lat = 4;
        redirect_now(32'h0000_0300, 32'h0000_0300);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clock);
            if (dut.contagem_reg >= 2 && mem_q.size() >= 1) found = 1'b1;
        end
        check("wait_fifo_and_pending", 32'(found), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_instr_valido", 32'(instr_valido), 32'd0);
        check("midrst_req_valido", 32'(req_valido), 32'd0);
        check("midrst_instr_pc", instr_pc, 32'h0);
        load_expected(32'h0, 40);
        instr_pronto = 1'b1;
        lat = 1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        mc0 = mon_count;
        @(negedge clock);
        check("restart_req_valido", 32'(req_valido), 32'd1);
        check("restart_req_endereco", req_endereco, 32'h0);
        repeat (10) @(negedge clock);
        check("restart_consumed_ge6", 32'(mon_count - mc0 >= 6), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule
